bshift_pipe: RTL
================

# bshift_pipe

Parametrised, pipelined barrel shifter with logical-left, logical-right, arithmetic-right and rotate-left modes, a binary shift amount and valid/ready flow control. It serves the encoder datapath, e.g. the transform, quantisation and CABAC helpers. It supersedes the fixed 64-bit single-cycle one-hot shifter: width, pipeline depth and tag passthrough are configurable, and it tolerates downstream backpressure.

## Interface
- `WIDTH`, 64: data width; power of two, 8..128.
- `BITS_PER_STAGE`, 2: shift-amount bits resolved per pipeline stage, 1..log2(WIDTH).
- `TAG_W`, 4: width of the sideband tag carried alongside the data (≥1).
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `in_valid_i` in 1: input beat valid.
- `in_ready_o` out 1: block accepts input this cycle.
- `op_i` in 2: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- `shift_i` in SW: shift amount. SW = log2(WIDTH), or WIDTH with `BSHIFT_ONEHOT_EN`.
- `tag_i` in TAG_W: sideband, returned unchanged.
- `data_i` in WIDTH: operand.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: downstream accepts result.
- `tag_o` out TAG_W: tag of the current result.
- `data_o` out WIDTH: result; all zero whenever `out_valid_o`=0.

## Operation
- NSTG = ceil(log2(WIDTH)/BITS_PER_STAGE). Stage k resolves shift bits [k·BPS +: BPS], LSB group first.
- Each stage register holds valid, op, remaining shift bits, tag and data.
- SRL and SRA: implemented as bit-reverse → left shift → bit-reverse.
  - Fill bit is 0 for SLL/SRL and `data_i[WIDTH-1]` for SRA.
  - The fill bit is captured at input and carried through the pipe.
- ROL: bits shifted out at the MSB re-enter at the LSB.
- Shift of 0 passes data unchanged in every mode.
- Binary amount is always < WIDTH, so no out-of-range case exists.
- Flow control: stage k loads when it is empty or when stage k+1 loads from it (bubble-collapsing). The output stage counts as advancing when `out_ready_i`=1.
- `in_ready_o` = stage 0 empty OR stage 0 advancing. It is purely combinational from `out_ready_i` and the stage valid bits, with no dependency on `in_valid_i`.
- A beat transfers on `in_valid_i & in_ready_o`. A result retires on `out_valid_o & out_ready_i`.
- While `out_valid_o`=1 and `out_ready_i`=0: `data_o`, `tag_o` and `out_valid_o` hold stable. Upstream stages keep filling bubbles until full, then `in_ready_o`=0.
- Order is strictly preserved. Up to NSTG beats are in flight.
- Accept and retire in the same cycle are allowed at full throughput.

## Timing
- Latency: NSTG cycles from input handshake to `out_valid_o`, with no stall. WIDTH=64, BPS=2 gives 3 cycles.
- Throughput: 1 beat/cycle when `out_ready_i` is held high.
- Reset (async assert, sync deassert handled externally):
  - all stage valid bits are cleared; `out_valid_o`=0, `data_o`=0, `tag_o`=0;
  - `in_ready_o`=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight beats. No partial result appears after reset.
- Stage registers with valid=0 are don't-care internally. The output data and tag are forced to 0 when invalid.

## Configuration
- `BSHIFT_ONEHOT_EN` defined:
  - `shift_i` is WIDTH bits, one-hot; bit n requests shift n.
  - The highest set bit wins when several are set; all-zero means shift 0.
  - The input is encoded to binary before stage 0, which adds one register stage, so latency is NSTG+1.
- Not defined: `shift_i` is a log2(WIDTH)-bit binary amount, and latency is NSTG.

## Test plan
- WIDTH=64, SLL, `data_i`=0x0000_0000_0000_00FF, shift 4, `out_ready_i`=1 → `data_o`=0x0000_0000_0000_0FF0 after 3 cycles, tag echoed.
- SRA, `data_i`=0x8000_0000_0000_0000, shift 63 → 0xFFFF_FFFF_FFFF_FFFF. SRL with the same inputs → 0x1. ROL 0x8000_0000_0000_0001 by 1 → 0x3.
- Back-to-back stream of 100 random beats with `out_ready_i`=1:
  - one result per cycle;
  - order and tags match the reference model;
  - `in_ready_o` never drops.
- Hold `out_ready_i`=0 for 10 cycles while driving input:
  - exactly NSTG beats are accepted, then `in_ready_o`=0;
  - `data_o`/`tag_o` stay stable;
  - on release, the beats drain in order with no loss or duplication.
- Assert `rst_i` with 2 beats in flight → outputs are zero in the same cycle (async). After deassert, no stale beats appear and `in_ready_o`=1.
- With `BSHIFT_ONEHOT_EN`:
  - `shift_i`=0x0000_0000_0000_0011 on SLL of 0x1 → 0x10 (highest bit, shift 4);
  - `shift_i`=0 → data unchanged;
  - latency is 4 cycles.

Source files
------------

// File: rtl/bshift_pipe.sv
// bshift_pipe: pipelined barrel shifter with valid/ready flow control.
//
// Modes (op_i): 00 SLL, 01 SRL, 10 SRA, 11 ROL. Right shifts are turned into
// left shifts by bit-reversing the operand on entry and the result on exit,
// so every stage only ever shifts left. The SRA fill bit is captured at the
// input and carried with the beat.
//
// Stage k resolves shift bits [k*BITS_PER_STAGE +: BITS_PER_STAGE], LSB group
// first; NSTG = ceil(log2(WIDTH)/BITS_PER_STAGE). Stages collapse bubbles:
// a stage loads when it is empty or when its successor loads from it.
//
// Optional build macro: BSHIFT_ONEHOT_EN
//   defined   - shift_i is WIDTH bits one-hot (highest set bit wins, all-zero
//               means shift 0); an extra register stage holds the encoded
//               amount, so latency is NSTG+1.
//   undefined - shift_i is a log2(WIDTH)-bit binary amount, latency NSTG.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   in_valid_i/in_ready_o   input handshake
//   op_i, shift_i, tag_i, data_i   operation, amount, sideband tag, operand
//   out_valid_o/out_ready_i output handshake
//   tag_o, data_o           result tag and data (zero when out_valid_o=0)

module bshift_pipe #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_STAGE = 2,
    parameter int TAG_W          = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [1:0]               op_i,
`ifdef BSHIFT_ONEHOT_EN
    input  logic [WIDTH-1:0]         shift_i,
`else
    input  logic [$clog2(WIDTH)-1:0] shift_i,
`endif
    input  logic [TAG_W-1:0]         tag_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [TAG_W-1:0]         tag_o,
    output logic [WIDTH-1:0]         data_o
);

    localparam int SW   = $clog2(WIDTH);
    localparam int BPS  = BITS_PER_STAGE;
    localparam int NSTG = (SW + BPS - 1) / BPS;
    localparam int PW   = NSTG * BPS;

    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [1:0]       op;
        logic             fill;
        logic [SW-1:0]    shamt;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] data;
    } beat_t;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
        return r;
    endfunction

    function automatic logic is_right(input logic [1:0] op);
        return (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Left shift through a double-width window: the low half supplies either
    // the fill bit or, for rotate, a second copy of the operand.
    function automatic logic [WIDTH-1:0] lshift(input logic [WIDTH-1:0] d,
                                                input logic rot,
                                                input logic fill,
                                                input logic [SW-1:0] s);
        logic [2*WIDTH-1:0] ext;
        ext = rot ? {d, d} : {d, {WIDTH{fill}}};
        ext = ext << s;
        return ext[2*WIDTH-1:WIDTH];
    endfunction

    // Keep only this stage's group of shift bits, at its true weight.
    function automatic logic [SW-1:0] stage_amt(input logic [SW-1:0] shamt, input int k);
        logic [PW-1:0] padded;
        logic [PW-1:0] grp;
        padded = PW'(shamt);
        grp = '0;
        grp[k*BPS +: BPS] = padded[k*BPS +: BPS];
        return grp[SW-1:0];
    endfunction

    logic [SW-1:0]   enc;
    beat_t           in_beat;
    beat_t           src0;
    beat_t           src   [NSTG];
    beat_t           stg_d [NSTG];
    beat_t           stg_q [NSTG];
    logic [NSTG-1:0] go;

`ifdef BSHIFT_ONEHOT_EN
    always_comb begin
        enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (shift_i[i]) enc = SW'(i);
        end
    end
`else
    assign enc = shift_i;
`endif

    always_comb begin
        in_beat       = '0;
        in_beat.valid = in_valid_i;
        in_beat.op    = op_i;
        in_beat.fill  = (op_i == OP_SRA) & data_i[WIDTH-1];
        in_beat.shamt = enc;
        in_beat.tag   = tag_i;
        in_beat.data  = is_right(op_i) ? bitrev(data_i) : data_i;
    end

    // Advance chain from the output back toward the input.
    always_comb begin
        logic g;
        go = '0;
        g  = out_ready_i;
        for (int k = NSTG - 1; k >= 0; k--) begin
            g     = !stg_q[k].valid | g;
            go[k] = g;
        end
    end

`ifdef BSHIFT_ONEHOT_EN
    beat_t pre_q;

    assign in_ready_o = !pre_q.valid | go[0];
    assign src0       = pre_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q <= '0;
        end else if (in_ready_o) begin
            pre_q <= in_beat;
        end
    end
`else
    assign in_ready_o = go[0];
    assign src0       = in_beat;
`endif

    always_comb begin
        src[0] = src0;
        for (int k = 1; k < NSTG; k++) src[k] = stg_q[k-1];
        for (int k = 0; k < NSTG; k++) begin
            stg_d[k]      = src[k];
            stg_d[k].data = lshift(src[k].data, src[k].op == OP_ROL, src[k].fill,
                                   stage_amt(src[k].shamt, k));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NSTG; k++) stg_q[k] <= '0;
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (go[k]) stg_q[k] <= stg_d[k];
            end
        end
    end

    assign out_valid_o = stg_q[NSTG-1].valid;

    always_comb begin
        data_o = '0;
        tag_o  = '0;
        if (stg_q[NSTG-1].valid) begin
            data_o = is_right(stg_q[NSTG-1].op) ? bitrev(stg_q[NSTG-1].data)
                                                : stg_q[NSTG-1].data;
            tag_o  = stg_q[NSTG-1].tag;
        end
    end

endmodule
